// File: rtl/irq_pending_ctrl.sv
// Avalon-MM interrupt aggregator: level/edge pending latches, mask, priority vector, overrun.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer on every irq_in bit.
module irq_pending_ctrl #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  localparam int unsigned DW = 16;
  localparam logic [DW-1:0] LINE_MASK = DW'((33'h1 << NUM_IRQ) - 33'h1);

  logic [DW-1:0] in_s, prev_s;
  logic [DW-1:0] pending, enable, mode, overrun;
  logic          ctrl_en;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_in;
      sync_q2 <= sync_q1;
    end
  end

  assign in_s = DW'(sync_q2);
`else
  assign in_s = DW'(irq_in);
`endif

  logic          wr_c;
  logic          wr_pend_c, wr_en_c, wr_mode_c, wr_ctrl_c, wr_ovr_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] edge_c, pend_clr_c, mode_chg_c, ovr_set_c, ovr_clr_c;
  logic [DW-1:0] pend_nxt_c, ovr_nxt_c, active_c;
  logic [3:0]    vec_idx_c;
  logic [DW-1:0] rd_mux_c;

  assign wr_c      = chipselect && !write_n;
  assign wr_pend_c = wr_c && (address == 3'd0);
  assign wr_en_c   = wr_c && (address == 3'd1);
  assign wr_mode_c = wr_c && (address == 3'd2);
  assign wr_ctrl_c = wr_c && (address == 3'd5);
  assign wr_ovr_c  = wr_c && (address == 3'd6);
  assign wdata_c   = writedata & LINE_MASK;

  // Next-state for pending/overrun; a mode change on a line wipes both of its bits.
  assign edge_c     = in_s & ~prev_s;
  assign pend_clr_c = wr_pend_c ? (wdata_c & mode) : '0;
  assign mode_chg_c = wr_mode_c ? (wdata_c ^ mode) : '0;
  assign ovr_set_c  = mode & edge_c & pending & ~pend_clr_c;
  assign ovr_clr_c  = wr_ovr_c ? wdata_c : '0;
  assign pend_nxt_c = ((mode & ((pending & ~pend_clr_c) | edge_c)) | (~mode & in_s))
                      & ~mode_chg_c & LINE_MASK;
  assign ovr_nxt_c  = ((overrun & ~ovr_clr_c) | ovr_set_c) & ~mode_chg_c & LINE_MASK;
  assign active_c   = pending & enable;

  // Fixed priority: lowest active index wins.
  always_comb begin
    vec_idx_c = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (active_c[i]) vec_idx_c = 4'(i);
    end
  end

  always_comb begin
    rd_mux_c = '0;
    case (address)
      3'd0: rd_mux_c = pending;
      3'd1: rd_mux_c = enable;
      3'd2: rd_mux_c = mode;
      3'd3: rd_mux_c = active_c;
      3'd4: rd_mux_c = (active_c != '0) ? {1'b1, 11'd0, vec_idx_c} : '0;
      3'd5: rd_mux_c = {15'd0, ctrl_en};
      3'd6: rd_mux_c = overrun;
      default: rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_s   <= '0;
      pending  <= '0;
      enable   <= '0;
      mode     <= '0;
      overrun  <= '0;
      ctrl_en  <= 1'b0;
      readdata <= '0;
      irq_out  <= 1'b0;
    end else begin
      prev_s   <= in_s;
      pending  <= pend_nxt_c;
      overrun  <= ovr_nxt_c;
      if (wr_en_c)   enable  <= wdata_c;
      if (wr_mode_c) mode    <= wdata_c;
      if (wr_ctrl_c) ctrl_en <= writedata[0];
      readdata <= rd_mux_c;
      irq_out  <= ctrl_en && (active_c != '0);
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed register scenarios plus random traffic vs a per-line model.
module tb_irq_pending_ctrl;

  localparam int N = 8;
`ifdef IRQ_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  bit          clk = 1'b0;
  logic        reset_n;
  logic [N-1:0] irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq_out;

  int nvec = 0;
  int nerr = 0;

  irq_pending_ctrl #(.NUM_IRQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  // Reference model: registers as plain vectors, updated line by line from the register-map rules.
  logic [15:0] m_pend, m_en, m_mode, m_ovr, m_prev, m_rd;
  logic [N-1:0] m_h1, m_h2;
  bit m_ctrl, m_irq;

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] act;
    logic [15:0] v;
    bit found;
    act = m_pend & m_en;
    v = 16'h0000;
    found = 1'b0;
    case (a)
      3'd0: v = m_pend;
      3'd1: v = m_en;
      3'd2: v = m_mode;
      3'd3: v = act;
      3'd4: for (int i = 0; i < 16; i++)
              if (!found && act[i]) begin v = 16'h8000 + 16'(i); found = 1'b1; end
      3'd5: v = {15'd0, m_ctrl};
      3'd6: v = m_ovr;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_ovr = '0; m_prev = '0;
      m_h1 = '0; m_h2 = '0; m_ctrl = 1'b0; m_rd = '0; m_irq = 1'b0;
    end else begin
      logic [15:0] ins, np, no;
      bit wr;
      ins = (DLY == 0) ? 16'(irq_in) : 16'(m_h2);
      m_h2 = m_h1;
      m_h1 = irq_in;
      m_rd = model_read(address);
      m_irq = m_ctrl && ((m_pend & m_en) != 16'h0);
      wr = chipselect && !write_n;
      np = m_pend;
      no = m_ovr;
      for (int i = 0; i < N; i++) begin
        bit rise, clr, setov;
        rise = ins[i] && !m_prev[i];
        clr = wr && address == 3'd0 && writedata[i];
        setov = 1'b0;
        if (!m_mode[i]) np[i] = ins[i];
        else if (rise) begin
          setov = m_pend[i] && !clr;
          np[i] = 1'b1;
        end else if (clr) np[i] = 1'b0;
        if (setov) no[i] = 1'b1;
        else if (wr && address == 3'd6 && writedata[i]) no[i] = 1'b0;
        if (wr && address == 3'd2 && writedata[i] != m_mode[i]) begin
          np[i] = 1'b0;
          no[i] = 1'b0;
        end
      end
      m_pend = np;
      m_ovr = no;
      m_prev = ins;
      if (wr && address == 3'd1) m_en = writedata & 16'((1 << N) - 1);
      if (wr && address == 3'd2) m_mode = writedata & 16'((1 << N) - 1);
      if (wr && address == 3'd5) m_ctrl = writedata[0];
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      nvec++;
      if (readdata !== m_rd || irq_out !== m_irq) begin
        nerr++;
        $display("FAIL cycle t=%0t readdata=%h exp=%h irq_out=%b exp=%b",
                 $time, readdata, m_rd, irq_out, m_irq);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int lat;
    reset_n = 1'b0; irq_in = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    chk("reset_readdata", readdata, 16'h0000);
    chk("reset_irq_out", 16'(irq_out), 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Level line 0
    bus_write(3'd1, 16'h0001);
    bus_write(3'd5, 16'h0001);
    irq_in = 8'h01; settle();
    bus_read(3'd0, d); chk("level_pend_high", d, 16'h0001);
    chk("level_irq_high", 16'(irq_out), 16'h0001);
    irq_in = 8'h00; settle();
    bus_read(3'd0, d); chk("level_pend_low", d, 16'h0000);
    chk("level_irq_low", 16'(irq_out), 16'h0000);
    irq_in = 8'h01; settle();
    bus_write(3'd0, 16'h0001);
    bus_read(3'd0, d); chk("level_w1c_ignored", d, 16'h0001);
    irq_in = 8'h00; settle();

    // Edge line 2 with W1C, then edge coinciding with W1C
    bus_write(3'd2, 16'h0004);
    irq_in = 8'h04; @(negedge clk); irq_in = 8'h00; settle();
    bus_read(3'd0, d); chk("edge_pend_set", d, 16'h0004);
    bus_write(3'd0, 16'h0004);
    bus_read(3'd0, d); chk("edge_w1c", d, 16'h0000);
    irq_in = 8'h04;
    repeat (DLY) @(negedge clk);
    bus_write(3'd0, 16'h0004);
    irq_in = 8'h00; settle();
    bus_read(3'd0, d); chk("edge_set_wins", d, 16'h0004);

    // Overrun on line 1
    bus_write(3'd2, 16'h0002);
    irq_in = 8'h02; @(negedge clk); irq_in = 8'h00; @(negedge clk);
    irq_in = 8'h02; @(negedge clk); irq_in = 8'h00; settle();
    bus_read(3'd6, d); chk("overrun_set", d, 16'h0002);
    bus_write(3'd6, 16'h0002);
    bus_read(3'd6, d); chk("overrun_w1c", d, 16'h0000);

    // Priority with lines 3 and 5
    bus_write(3'd2, 16'h0028);
    bus_write(3'd1, 16'h00FF);
    irq_in = 8'h28; @(negedge clk); irq_in = 8'h00; settle();
    bus_read(3'd4, d); chk("vector_3", d, 16'h8003);
    bus_write(3'd0, 16'h0008);
    bus_read(3'd4, d); chk("vector_5", d, 16'h8005);
    bus_write(3'd0, 16'h0028);
    bus_read(3'd4, d); chk("vector_none", d, 16'h0000);

    // Masking and global enable
    bus_write(3'd2, 16'h0010);
    bus_write(3'd1, 16'h0000);
    irq_in = 8'h10; @(negedge clk); irq_in = 8'h00; settle();
    bus_read(3'd3, d); chk("active_masked", d, 16'h0000);
    chk("irq_masked", 16'(irq_out), 16'h0000);
    bus_write(3'd5, 16'h0000);
    bus_write(3'd1, 16'h0010);
    repeat (2) @(negedge clk);
    chk("irq_gie_off", 16'(irq_out), 16'h0000);
    bus_write(3'd5, 16'h0001);
    chk("irq_gie_same_clk", 16'(irq_out), 16'h0000);
    @(negedge clk);
    chk("irq_gie_next_clk", 16'(irq_out), 16'h0001);

    // Input-to-irq_out latency on level line 0
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h0001);
    settle();
    irq_in = 8'h01;
    lat = 0;
    while (lat < 10 && irq_out !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 16'(lat), 16'(DLY + 2));

    // Reset mid-operation
    @(negedge clk);
    reset_n = 1'b0; irq_in = 8'h00;
    #1;
    chk("midreset_readdata", readdata, 16'h0000);
    chk("midreset_irq_out", 16'(irq_out), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      chk("post_reset_reg", d, 16'h0000);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      address = 3'($urandom);
      writedata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
      end else begin
        chipselect = 1'($urandom); write_n = 1'b1;
      end
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
